// File: rtl/dae_frame_serializer.sv
// dae_frame_serializer: buffers whole 4-lane frames from the DAE core and
// replays them as one paced, handshaked sample stream (lane 0 first).
module dae_frame_serializer #(
  parameter int WIDTH    = 8,
  parameter int FRAMES   = 2,
  parameter int RATE_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic signed [WIDTH-1:0] frame0,
  input  logic signed [WIDTH-1:0] frame1,
  input  logic signed [WIDTH-1:0] frame2,
  input  logic signed [WIDTH-1:0] frame3,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    sample_last,
  output logic [15:0]             underrun_cnt
);

  localparam int PTR_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int CNT_W = $clog2(FRAMES + 1);
  localparam int PC_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAMES);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FRAMES - 1);
  localparam logic [PC_W-1:0]  PC_RELOAD = PC_W'(RATE_DIV - 1);

  typedef enum logic {S_IDLE, S_VALID} state_e;

  // Circular pointer advance that also handles non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Diagnostic counter: sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [3:0][WIDTH-1:0] mem_q [FRAMES];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            idx_q, idx_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  state_e                state_q, state_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic                  last_q, last_d;
  logic                  primed_q;
  logic [15:0]           und_q;

  logic push, pop, load, reg_free, pc_zero, fifo_empty, starve;
  logic [WIDTH-1:0] head_lane;

  assign frame_ready = (count_q < CNT_FULL);
  assign push        = frame_valid && frame_ready;
  assign fifo_empty  = (count_q == '0);
  assign pc_zero     = (pc_q == '0);
  assign reg_free    = (state_q == S_IDLE) || sample_ready;
  assign load        = reg_free && pc_zero && !fifo_empty;
  assign pop         = load && (idx_q == 2'd3);
  assign starve      = primed_q && reg_free && pc_zero && fifo_empty && sample_ready;
  assign head_lane   = mem_q[rd_ptr_q][idx_q];

  assign sample_out   = out_q;
  assign sample_valid = (state_q == S_VALID);
  assign sample_last  = last_q;
  assign underrun_cnt = und_q;

  // Frame storage: payload only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {frame3, frame2, frame1, frame0};
  end

  // Occupancy: push and pop on the same edge cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Output register / lane sequencer / pacer next state.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    last_d  = last_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    if (load) begin
      out_d   = head_lane;
      last_d  = (idx_q == 2'd3);
      idx_d   = idx_q + 2'd1;
      pc_d    = PC_RELOAD;
      state_d = S_VALID;
    end else begin
      if (reg_free) state_d = S_IDLE;
      if (!pc_zero) pc_d = pc_q - 1'b1;
    end
  end

  // Control and output state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      pc_q     <= '0;
      state_q  <= S_IDLE;
      out_q    <= '0;
      last_q   <= 1'b0;
      primed_q <= 1'b0;
      und_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push) primed_q <= 1'b1;
      if (starve) und_q <= sat_inc16(und_q);
      count_q <= count_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      state_q <= state_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_dae_frame_serializer.sv
// Bench for dae_frame_serializer: directed and random steps checked against a
// queue-based reference model and an accepted-sample scoreboard.
module tb_dae_frame_serializer;
  localparam int FR = 2;
  localparam int RD = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       fv = 1'b0, fr_rdy;
  logic [7:0] f0 = '0, f1 = '0, f2 = '0, f3 = '0;
  logic [7:0] s_out;
  logic       s_valid, s_last, s_ready = 1'b0;
  logic [15:0] und;

  logic       fv4 = 1'b0, fr_rdy4;
  logic [7:0] f04 = '0, f14 = '0, f24 = '0, f34 = '0;
  logic [7:0] s_out4;
  logic       s_valid4, s_last4, s_ready4 = 1'b0;
  logic [15:0] und4;

  dae_frame_serializer #(.WIDTH(8), .FRAMES(FR), .RATE_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv), .frame_ready(fr_rdy),
    .frame0(f0), .frame1(f1), .frame2(f2), .frame3(f3),
    .sample_out(s_out), .sample_valid(s_valid), .sample_ready(s_ready),
    .sample_last(s_last), .underrun_cnt(und));

  dae_frame_serializer #(.WIDTH(8), .FRAMES(2), .RATE_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv4), .frame_ready(fr_rdy4),
    .frame0(f04), .frame1(f14), .frame2(f24), .frame3(f34),
    .sample_out(s_out4), .sample_valid(s_valid4), .sample_ready(s_ready4),
    .sample_last(s_last4), .underrun_cnt(und4));

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [7:0]  sb[$];
  int          m_idx, m_pc, m_und;
  bit          m_valid, m_last, m_primed, m_pushed;
  logic [7:0]  m_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic model_reset();
    mq.delete(); sb.delete();
    m_idx = 0; m_pc = 0; m_und = 0;
    m_valid = 0; m_last = 0; m_primed = 0; m_pushed = 0;
    m_out = '0;
  endtask

  task automatic cmp_all();
    chk("frame_ready",  32'(fr_rdy),  32'(mq.size() < FR));
    chk("sample_valid", 32'(s_valid), 32'(m_valid));
    chk("sample_out",   32'(s_out),   32'(m_out));
    chk("sample_last",  32'(s_last),  32'(m_last));
    chk("underrun_cnt", 32'(und),     32'(m_und));
  endtask

  // One clock of the main DUT: advance the model, then compare after the edge.
  task automatic tick();
    bit free, ld, stall, pl;
    logic [7:0] po;
    logic [31:0] h;
    stall = s_valid && !s_ready;
    po = s_out;
    pl = s_last;
    if (s_valid && s_ready) begin
      if (sb.size() == 0) fail("accept_extra");
      else chk("accept_seq", 32'(s_out), 32'(sb.pop_front()));
    end
    free = !m_valid || s_ready;
    m_pushed = fv && (mq.size() < FR);
    ld = free && (m_pc == 0) && (mq.size() != 0);
    if (m_primed && free && m_pc == 0 && mq.size() == 0 && s_ready && m_und < 65535)
      m_und++;
    if (ld) begin
      h = mq[0];
      m_out = h[m_idx*8 +: 8];
      m_last = (m_idx == 3);
      if (m_idx == 3) void'(mq.pop_front());
      m_idx = (m_idx + 1) % 4;
      m_valid = 1;
      m_pc = RD - 1;
    end else begin
      if (free) m_valid = 0;
      if (m_pc > 0) m_pc--;
    end
    if (m_pushed) begin
      mq.push_back({f3, f2, f1, f0});
      sb.push_back(f0); sb.push_back(f1); sb.push_back(f2); sb.push_back(f3);
      m_primed = 1;
    end
    @(posedge clk); #1;
    cmp_all();
    if (stall) begin
      chk("stall_out",  32'(s_out),  32'(po));
      chk("stall_last", 32'(s_last), 32'(pl));
    end
  endtask

  task automatic send(input logic [31:0] fr, input int bound);
    fv = 1'b1;
    {f3, f2, f1, f0} = fr;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (m_pushed) break;
    end
    if (!m_pushed) fail("send_timeout");
    fv = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fa, fb, fr;
    logic [7:0]  pe [8];
    int lat;

    // Reset, then idle with no frames
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; cmp_all(); end
    rst_n = 1'b1;
    s_ready = 1'b1;
    repeat (20) tick();

    // Pacing on the RATE_DIV=4 instance
    fa = $urandom; fb = $urandom;
    for (int i = 0; i < 4; i++) begin pe[i] = fa[i*8 +: 8]; pe[4+i] = fb[i*8 +: 8]; end
    s_ready4 = 1'b1; fv4 = 1'b1; {f34, f24, f14, f04} = fa;
    @(posedge clk); #1;
    {f34, f24, f14, f04} = fb;
    for (int k = 1; k <= 29; k++) begin
      @(posedge clk); #1;
      if (k == 1) fv4 = 1'b0;
      chk("pace_valid", 32'(s_valid4), 32'(((k - 1) % 4) == 0));
      chk("pace_out",   32'(s_out4),   32'(pe[(k - 1) / 4]));
      chk("pace_last",  32'(s_last4),  32'((((k - 1) / 4) % 4) == 3));
    end
    chk("pace_underrun", 32'(und4), 32'(0));
    chk("pace_drained",  32'(fr_rdy4), 32'(1));

    // Single frame {10,-20,30,-40}
    send({8'hD8, 8'h1E, 8'hEC, 8'h0A}, 5);
    tick(); chk("sf_lane0", 32'(s_out), 32'h0A); chk("sf_last0", 32'(s_last), 32'(0));
    tick(); chk("sf_lane1", 32'(s_out), 32'hEC);
    tick(); chk("sf_lane2", 32'(s_out), 32'h1E);
    tick(); chk("sf_lane3", 32'(s_out), 32'hD8); chk("sf_last3", 32'(s_last), 32'(1));
    tick(); chk("sf_idle", 32'(s_valid), 32'(0)); chk("sf_und1", 32'(und), 32'(1));
    tick(); chk("sf_und2", 32'(und), 32'(2));

    // Backpressure until full, then release
    s_ready = 1'b0;
    send($urandom, 5);
    send($urandom, 5);
    fv = 1'b1; {f3, f2, f1, f0} = $urandom;
    repeat (5) begin tick(); chk("full_ready_low", 32'(fr_rdy), 32'(0)); end
    s_ready = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!m_pushed && lat < 20);
    fv = 1'b0;
    if (!m_pushed) fail("full_accept_timeout");
    chk("full_accept_latency", 32'(lat), 32'(4));
    repeat (16) tick();
    chk("full_drained", 32'(sb.size()), 32'(0));

    // Random stalls and random frame arrivals
    for (int c = 0; c < 400; c++) begin
      if (!fv || m_pushed) begin
        fv = ($urandom % 2) == 1;
        {f3, f2, f1, f0} = $urandom;
      end
      s_ready = ($urandom % 3) != 0;
      tick();
    end
    fv = 1'b0; s_ready = 1'b1;
    repeat (16) tick();
    chk("stall_drained", 32'(sb.size()), 32'(0));

    // Reset in the middle of a frame
    fr = $urandom;
    send(fr, 5);
    tick(); tick();
    chk("mr_lane1", 32'(s_out), 32'(fr[15:8]));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mr_out0",   32'(s_out),   32'(0));
    chk("mr_valid0", 32'(s_valid), 32'(0));
    chk("mr_last0",  32'(s_last),  32'(0));
    chk("mr_und0",   32'(und),     32'(0));
    chk("mr_ready1", 32'(fr_rdy),  32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_all();
    fr = $urandom;
    send(fr, 5);
    tick();
    chk("mr_first_lane0", 32'(s_out), 32'(fr[7:0]));
    chk("mr_first_valid", 32'(s_valid), 32'(1));
    repeat (6) tick();

    // Long starvation to reach saturation
    repeat (70000) tick();
    chk("und_sat", 32'(und), 32'hFFFF);
    repeat (5) tick();
    chk("und_hold", 32'(und), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
